ahb_sram_slave: RTL
===================

Name: ahb_sram_slave

Overview:
AHB-Lite responder that terminates master transfers into an on-chip word-organised SRAM. It is the slave counterpart to the processor-side AHB master. It serves single transfers and INCR8 bursts from the I-cache and D-cache fill paths. A configurable number of wait states is inserted on NONSEQ beats only, and protocol violations get the two-cycle ERROR response.

Parameters:
MEM_WORDS, 1024, SRAM depth in 32-bit words (power of two); valid byte offset range is 0 to MEM_WORDS*4-1.
WAIT_STATES, 1, HREADYOUT-low cycles inserted before completing each NONSEQ data phase (0 allowed).

Ports:
HCLK  input  1  bus clock; all state on rising edge.
HRESETn  input  1  asynchronous, active-low reset.
HSEL  input  1  slave select from address decoder.
HADDR  input  32  byte address (address phase).
HWRITE  input  1  1 = write.
HSIZE  input  3  0 = byte, 1 = halfword, 2 = word.
HTRANS  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
HBURST  input  3  accepted, ignored.
HPROT  input  4  accepted, ignored.
HWDATA  input  32  write data (data phase).
HREADY  input  1  bus-level ready (mux output).
HREADYOUT  output  1  slave ready.
HRESP  output  1  0 OKAY, 1 ERROR.
HRDATA  output  32  read data.

Behaviour:
- Reset (async): state IDLE, HREADYOUT=1, HRESP=0, HRDATA=0, pending transfer cleared, wait counter=0. SRAM contents are not reset.
- Reset asserted mid-transfer abandons the transfer. A write in wait state is not committed.
- Address-phase sample: on a rising edge with HSEL && HREADY && HTRANS[1]=1:
  - register addr, write, size, and a NONSEQ/SEQ flag;
  - evaluate the error condition.
- IDLE/BUSY, or HSEL=0, when sampled: no pending transfer. The next cycle is OKAY, zero-wait, with no memory access.
- Error condition, any of:
  - HSIZE > 2;
  - halfword with HADDR[0]=1;
  - word with HADDR[1:0]!=0;
  - HADDR >= MEM_WORDS*4.
- States:
  - IDLE: HREADYOUT=1, HRESP=0.
    - Error sample -> ERR1.
    - NONSEQ with WAIT_STATES>0 -> WAIT, counter loaded with WAIT_STATES-1.
    - SEQ, or WAIT_STATES=0 -> DATA.
  - WAIT: HREADYOUT=0, HRESP=0. Counter decrements; at 0 -> DATA.
  - DATA: HREADYOUT=1, HRESP=0. Completing cycle.
    - A write commits HWDATA lanes on the closing edge.
    - A read drives HRDATA = mem[addr_q[.. :2]] (full word, all lanes).
    - On the closing edge a new address phase may be sampled: same rules as IDLE, giving back-to-back pipelining.
    - Otherwise -> IDLE.
  - ERR1: HREADYOUT=0, HRESP=1 -> ERR2.
  - ERR2: HREADYOUT=1, HRESP=1. No memory access. May sample a new address phase as in DATA, else -> IDLE.
- Byte enables from size and addr_q[1:0]:
  - byte: lane addr_q[1:0];
  - halfword: lanes {addr_q[1],0} and {addr_q[1],1};
  - word: all four lanes.
  - Unselected bytes are unchanged.
- HRDATA is 0 in every cycle that is not a read completion.
- Read-after-write hazard: a read whose data phase directly follows a write data phase to the same word returns the newly written bytes.
- SEQ beats are always zero-wait, so an INCR8 burst costs WAIT_STATES+8 cycles of data phase.
- An error inside a burst does not lock the slave. Subsequent SEQ/NONSEQ transfers are served normally.
- Address offset bits above log2(MEM_WORDS*4) are not aliased; they trigger ERROR.

Test Plan:
1. WAIT_STATES=2: word write 0xDEADBEEF at 0x10, then single read 0x10 -> each NONSEQ sees HREADYOUT low 2 cycles, then high; HRDATA=0xDEADBEEF, HRESP=0.
2. INCR8 read from 0x20 (NONSEQ + 7 SEQ) after preloading words 0x20..0x3C with 1..8 -> 2 wait cycles on beat 0 only; beats return 1..8 consecutively with HREADYOUT=1.
3. Byte write 0xAB to 0x13, halfword write 0x1234 to 0x10, then word read 0x10 -> 0xABAD1234.
4. Word access at 0x02, and byte access at 0x1000 with MEM_WORDS=1024 -> each gives one cycle HREADYOUT=0/HRESP=1, then one cycle HREADYOUT=1/HRESP=1; memory unchanged; next valid transfer returns OKAY.
5. Pipelined write 0x55AA55AA to 0x40 immediately followed by read 0x40 -> read data phase returns 0x55AA55AA.
6. HRESETn pulsed low during the WAIT of a write to 0x80 (old value 0x0) -> HREADYOUT=1, HRESP=0, HRDATA=0 immediately; later read of 0x80 returns 0x0.

Source files
------------

// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between one master and the SRAM responder.
interface ahb_sram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [2:0]  HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HWRITE, HSIZE, HTRANS, HBURST, HPROT, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HWRITE, HSIZE, HTRANS, HBURST, HPROT, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder in front of a word-organised SRAM. NONSEQ beats take
// WAIT_STATES extra cycles, SEQ beats are zero-wait, bad accesses get the
// two-cycle ERROR response. All bus outputs are registered.
module ahb_sram_slave #(
  parameter int MEM_WORDS   = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  ahb_sram_slave_if.slave bus
);
  localparam int AW = $clog2(MEM_WORDS * 4);
  localparam int IW = $clog2(MEM_WORDS);
  localparam int CW = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = (WAIT_STATES > 0) ? CW'(WAIT_STATES - 1) : '0;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t          state;
  logic [AW-1:0]   addr_q;
  logic            write_q;
  logic [1:0]      size_q;
  logic [CW-1:0]   cnt;
  logic            ready_q;
  logic            resp_q;
  logic [31:0]     rdata_q;
  logic [31:0]     mem [MEM_WORDS];

  logic            sample;
  logic            addr_err;
  logic            nonseq;
  logic            wr_en;
  logic [3:0]      wr_be;
  logic [IW-1:0]   wr_idx;
  logic [IW-1:0]   rd_idx;
  logic            fwd;
  logic [31:0]     rd_word;
  logic            unused;

  // Byte lanes touched by an access of the given size at the given offset.
  function automatic logic [3:0] lanes(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'd0:    lanes = 4'b0001 << a;
      2'd1:    lanes = a[1] ? 4'b1100 : 4'b0011;
      default: lanes = 4'b1111;
    endcase
  endfunction

  // Address-phase decode, write lanes, and read word with write forwarding.
  always_comb begin
    sample   = bus.HSEL && bus.HREADY && bus.HTRANS[1];
    nonseq   = !bus.HTRANS[0];
    addr_err = (bus.HSIZE > 3'd2)
            || (bus.HSIZE == 3'd1 && bus.HADDR[0])
            || (bus.HSIZE == 3'd2 && bus.HADDR[1:0] != 2'b00)
            || (bus.HADDR[31:AW] != '0);
    wr_en    = (state == S_DATA) && write_q;
    wr_be    = lanes(size_q, addr_q[1:0]);
    wr_idx   = addr_q[AW-1:2];
    // In WAIT the read index comes from the held address; otherwise the read
    // is launched straight from the address phase being sampled.
    rd_idx   = (state == S_WAIT) ? addr_q[AW-1:2] : bus.HADDR[AW-1:2];
    // A write closing on this edge to the same word must be visible to a read
    // whose data phase starts right after it.
    fwd      = wr_en && (wr_idx == rd_idx);
    rd_word  = mem[rd_idx];
    for (int i = 0; i < 4; i++)
      if (fwd && wr_be[i]) rd_word[8*i +: 8] = bus.HWDATA[8*i +: 8];
    unused   = ^{bus.HBURST, bus.HPROT};
  end

  // SRAM write port: commits the enabled lanes on the closing edge of a write.
  always_ff @(posedge HCLK) begin
    if (wr_en)
      for (int i = 0; i < 4; i++)
        if (wr_be[i]) mem[wr_idx][8*i +: 8] <= bus.HWDATA[8*i +: 8];
  end

  // Transfer FSM; IDLE, DATA and ERR2 all accept a new address phase.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state   <= S_IDLE;
      ready_q <= 1'b1;
      resp_q  <= 1'b0;
      rdata_q <= '0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        S_WAIT: begin
          if (cnt == '0) begin
            state   <= S_DATA;
            ready_q <= 1'b1;
            rdata_q <= write_q ? 32'h0 : rd_word;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_ERR1: begin
          state   <= S_ERR2;
          ready_q <= 1'b1;
          resp_q  <= 1'b1;
        end
        default: begin
          state   <= S_IDLE;
          ready_q <= 1'b1;
          resp_q  <= 1'b0;
          rdata_q <= '0;
          if (sample) begin
            addr_q  <= bus.HADDR[AW-1:0];
            write_q <= bus.HWRITE;
            size_q  <= bus.HSIZE[1:0];
            if (addr_err) begin
              state   <= S_ERR1;
              ready_q <= 1'b0;
              resp_q  <= 1'b1;
            end else if ((WAIT_STATES > 0) && nonseq) begin
              state   <= S_WAIT;
              ready_q <= 1'b0;
              cnt     <= CNT_INIT;
            end else begin
              state <= S_DATA;
              if (!bus.HWRITE) rdata_q <= rd_word;
            end
          end
        end
      endcase
    end
  end

  assign bus.HREADYOUT = ready_q;
  assign bus.HRESP     = resp_q;
  assign bus.HRDATA    = rdata_q;
endmodule
